// File: rtl/scroll_sched_if.sv
// Bundles the raster position, button controls and painter-facing outputs of scroll_sched.
interface scroll_sched_if #(
  parameter int OFS_W = 6
);
  logic [9:0]       sx;
  logic [9:0]       sy;
  logic             run_toggle;
  logic             step_req;
  logic             dir;
  logic [3:0]       speed;
  logic [OFS_W-1:0] shift_offset;
  logic             wrap;
  logic             running;
  logic             frame_strobe;

  modport master (
    output sx, sy, run_toggle, step_req, dir, speed,
    input  shift_offset, wrap, running, frame_strobe
  );

  modport slave (
    input  sx, sy, run_toggle, step_req, dir, speed,
    output shift_offset, wrap, running, frame_strobe
  );
endinterface

// File: rtl/scroll_sched.sv
// Frame-locked scroll offset scheduler: advances the banner offset only at the start of
// vertical blanking, once every 'speed' frames, with run/pause/single-step control.
module scroll_sched #(
  parameter int BMAP_COLS = 60,
  parameter int VIEW_COLS = 20,
  parameter int V_ACTIVE  = 480,
  parameter int OFS_W     = 6
) (
  input  logic           clk_pix,
  input  logic           rst,
  scroll_sched_if.slave  bus
);
  localparam logic [OFS_W-1:0] MAX_SHIFT = OFS_W'(BMAP_COLS - VIEW_COLS);

  typedef enum logic [1:0] {RUN, PAUSE, STEP} state_t;

  state_t           state;
  logic [3:0]       frame_cnt;
  logic [OFS_W-1:0] offset;
  logic             wrap;
  logic             frame_strobe;

  logic             fs;
  logic [3:0]       spd;
  logic [4:0]       cnt_inc;
  logic [OFS_W-1:0] adv_val;
  logic             adv_wrap;

  assign fs      = (bus.sx == 10'd0) && (bus.sy == 10'(V_ACTIVE));
  assign spd     = (bus.speed == 4'd0) ? 4'd1 : bus.speed;
  assign cnt_inc = {1'b0, frame_cnt} + 5'd1;

  // Next offset if an advance happens this cycle, wrapping at both ends of 0..MAX_SHIFT.
  always_comb begin
    adv_val  = offset;
    adv_wrap = 1'b0;
    if (!bus.dir) begin
      if (offset == MAX_SHIFT) begin
        adv_val  = '0;
        adv_wrap = 1'b1;
      end else begin
        adv_val  = offset + 1'b1;
      end
    end else begin
      if (offset == '0) begin
        adv_val  = MAX_SHIFT;
        adv_wrap = 1'b1;
      end else begin
        adv_val  = offset - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state        <= RUN;
      frame_cnt    <= '0;
      offset       <= '0;
      wrap         <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= fs;
      wrap         <= 1'b0;
      case (state)
        RUN: begin
          if (frame_strobe) begin
            if (cnt_inc >= {1'b0, spd}) begin
              offset    <= adv_val;
              wrap      <= adv_wrap;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= cnt_inc[3:0];
            end
          end
          // A coincident strobe is still honoured above; only the next state changes.
          if (bus.run_toggle) begin
            state     <= PAUSE;
            frame_cnt <= '0;
          end
        end
        PAUSE: begin
          frame_cnt <= '0;
          if (bus.run_toggle)    state <= RUN;
          else if (bus.step_req) state <= STEP;
        end
        STEP: begin
          frame_cnt <= '0;
          if (frame_strobe) begin
            offset <= adv_val;
            wrap   <= adv_wrap;
            state  <= PAUSE;
          end
          if (bus.run_toggle) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.shift_offset = offset;
  assign bus.wrap         = wrap;
  assign bus.running      = (state == RUN);
  assign bus.frame_strobe = frame_strobe;
endmodule

// File: tb/tb_scroll_sched.sv
// Directed bench for scroll_sched: drives raster positions directly, one strobe per frame.
module tb_scroll_sched;
  logic clk_pix = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   model_ofs;
  int   wraps;

  scroll_sched_if #(.OFS_W(6)) bus ();

  scroll_sched #(
    .BMAP_COLS(60), .VIEW_COLS(20), .V_ACTIVE(480), .OFS_W(6)
  ) dut (
    .clk_pix (clk_pix),
    .rst     (rst),
    .bus     (bus.slave)
  );

  always #20 clk_pix = ~clk_pix;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic idle(input int n);
    bus.sx = 10'd100;
    bus.sy = 10'd200;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    model_ofs = 0;
  endtask

  task automatic pulse_toggle();
    bus.run_toggle = 1'b1;
    tick();
    bus.run_toggle = 1'b0;
  endtask

  task automatic pulse_step();
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
  endtask

  // One frame: hit (0,V_ACTIVE), see the registered strobe, then the offset update.
  task automatic frame(input string tag, input int exp_ofs, input int exp_wrap,
                       input int exp_run, input bit tog);
    bus.sx = 10'd0;
    bus.sy = 10'd480;
    tick();
    bus.sx = 10'd1;
    chk({tag, ".strobe"}, int'(bus.frame_strobe), 1);
    chk({tag, ".hold1"}, int'(bus.shift_offset), model_ofs);
    bus.run_toggle = tog;
    tick();
    bus.run_toggle = 1'b0;
    chk({tag, ".ofs"}, int'(bus.shift_offset), exp_ofs);
    chk({tag, ".wrap"}, int'(bus.wrap), exp_wrap);
    chk({tag, ".run"}, int'(bus.running), exp_run);
    if (bus.wrap) wraps++;
    idle(1);
    chk({tag, ".wrap_low"}, int'(bus.wrap), 0);
    chk({tag, ".strobe_low"}, int'(bus.frame_strobe), 0);
    model_ofs = exp_ofs;
  endtask

  initial begin
    bus.sx = 10'd100; bus.sy = 10'd200;
    bus.run_toggle = 1'b0; bus.step_req = 1'b0;
    bus.dir = 1'b0; bus.speed = 4'd1;
    rst = 1'b0;
    wraps = 0;

    // 1: reset values, then 45 frames at speed 1 going left.
    do_reset();
    chk("rst.ofs", int'(bus.shift_offset), 0);
    chk("rst.run", int'(bus.running), 1);
    chk("rst.wrap", int'(bus.wrap), 0);
    chk("rst.strobe", int'(bus.frame_strobe), 0);
    for (int k = 1; k <= 45; k++)
      frame("t1", k % 41, (k == 41) ? 1 : 0, 1, 1'b0);
    chk("t1.final", int'(bus.shift_offset), 4);
    chk("t1.wraps", wraps, 1);

    // 2: speed 3, then speed 1 with frame_cnt at 2, then speed 0.
    do_reset();
    bus.speed = 4'd3;
    frame("t2a", 0, 0, 1, 1'b0);
    frame("t2b", 0, 0, 1, 1'b0);
    frame("t2c", 1, 0, 1, 1'b0);
    frame("t2d", 1, 0, 1, 1'b0);
    frame("t2e", 1, 0, 1, 1'b0);
    frame("t2f", 2, 0, 1, 1'b0);
    frame("t2g", 2, 0, 1, 1'b0);
    frame("t2h", 2, 0, 1, 1'b0);
    bus.speed = 4'd1;
    frame("t2i", 3, 0, 1, 1'b0);
    bus.speed = 4'd0;
    frame("t2j", 4, 0, 1, 1'b0);
    frame("t2k", 5, 0, 1, 1'b0);

    // 3: reverse direction from reset wraps to 40, then flip back.
    do_reset();
    bus.speed = 4'd1;
    bus.dir = 1'b1;
    frame("t3a", 40, 1, 1, 1'b0);
    frame("t3b", 39, 0, 1, 1'b0);
    frame("t3c", 38, 0, 1, 1'b0);
    bus.dir = 1'b0;
    frame("t3d", 39, 0, 1, 1'b0);

    // 4: pause at 10, frames pass, three step requests give one advance.
    do_reset();
    for (int k = 1; k <= 10; k++) frame("t4run", k, 0, 1, 1'b0);
    pulse_toggle();
    chk("t4.paused", int'(bus.running), 0);
    for (int k = 0; k < 5; k++) frame("t4hold", 10, 0, 0, 1'b0);
    pulse_step(); idle(1);
    pulse_step(); idle(1);
    pulse_step();
    chk("t4.step_run", int'(bus.running), 0);
    frame("t4step", 11, 0, 0, 1'b0);
    frame("t4after", 11, 0, 0, 1'b0);
    frame("t4after2", 11, 0, 0, 1'b0);

    // 5: toggle coincident with the strobe in RUN and in STEP.
    pulse_toggle();
    chk("t5.resumed", int'(bus.running), 1);
    frame("t5run_tog", 12, 0, 0, 1'b1);
    frame("t5paused", 12, 0, 0, 1'b0);
    pulse_step();
    frame("t5step_tog", 13, 0, 1, 1'b1);
    frame("t5run", 14, 0, 1, 1'b0);

    // 6: reset mid-frame while paused at 25.
    for (int k = 15; k <= 25; k++) frame("t6run", k, 0, 1, 1'b0);
    pulse_toggle();
    idle(3);
    chk("t6.paused", int'(bus.running), 0);
    chk("t6.pre_ofs", int'(bus.shift_offset), 25);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_ofs = 0;
    chk("t6.rst_ofs", int'(bus.shift_offset), 0);
    chk("t6.rst_run", int'(bus.running), 1);
    chk("t6.rst_wrap", int'(bus.wrap), 0);
    idle(2);
    chk("t6.no_strobe", int'(bus.frame_strobe), 0);
    frame("t6resume", 1, 0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scroll_sched.md
Name: scroll_sched

Overview:
- Controller for the 32x-scaled scrolling-banner painter. Produces the column offset the painter adds to its bitmap column index.
- Advances the offset only during vertical blanking, once every N frames, so the visible text never tears mid-frame.
- Provides run/pause, single-step and direction control from debounced button pulses. Replaces the free-running clock-count divider with frame-locked scheduling.

Parameters:
- BMAP_COLS, 60, total bitmap columns.
- VIEW_COLS, 20, columns visible on screen (640/32).
- V_ACTIVE, 480, first non-active line; the frame strobe fires on this line.
- OFS_W, 6, offset width; must satisfy 2^OFS_W > BMAP_COLS-VIEW_COLS.

Ports:
- clk_pix  in  1  pixel clock, 25 MHz
- rst  in  1  synchronous active-high reset
- sx  in  10  current horizontal pixel position
- sy  in  10  current vertical line position
- run_toggle  in  1  one-cycle pulse; toggles run/pause
- step_req  in  1  one-cycle pulse; single step while paused
- dir  in  1  0 = offset increments (text moves left), 1 = offset decrements
- speed  in  4  frames per step; 0 is treated as 1
- shift_offset  out  OFS_W  column offset to the painter, range 0..MAX_SHIFT
- wrap  out  1  one-cycle pulse when the offset wraps
- running  out  1  high in RUN state
- frame_strobe  out  1  one-cycle pulse at the start of vertical blanking

Behaviour:
- One clock (clk_pix). Reset is synchronous, active-high; all state updates on the rising edge of clk_pix.
- MAX_SHIFT = BMAP_COLS - VIEW_COLS, which is 40 by default.
- Reset values:
  - shift_offset = 0, wrap = 0, frame_strobe = 0.
  - State = RUN, so running = 1; the block scrolls out of reset.
  - Internal frame_cnt = 0, step_pend = 0.
- Frame strobe:
  - Internal signal fs = (sx == 0 && sy == V_ACTIVE), evaluated combinationally.
  - frame_strobe is fs registered: high for exactly one cycle, one cycle after the match. It fires once per frame.
  - All advancing uses registered frame_strobe, so the offset changes 2 cycles after the (0, V_ACTIVE) position. This is always inside blanking.
- Effective speed: spd = (speed == 0) ? 1 : speed. It is sampled on every strobe, so a speed change takes effect at the next strobe.
- Advance operation:
  - dir = 0: offset = (offset == MAX_SHIFT) ? 0 : offset + 1.
  - dir = 1: offset = (offset == 0) ? MAX_SHIFT : offset - 1.
  - wrap = 1 in the same cycle the wrapped value is loaded; otherwise wrap = 0.
  - Offset never leaves 0..MAX_SHIFT. dir is sampled at the advance cycle.
- States:
  - RUN:
    - On frame_strobe: if frame_cnt + 1 >= spd, advance and clear frame_cnt; otherwise increment frame_cnt.
    - run_toggle goes to PAUSE.
    - step_req is ignored.
  - PAUSE:
    - frame_cnt is held at 0.
    - step_req goes to STEP.
    - run_toggle goes to RUN with frame_cnt = 0.
  - STEP:
    - At the next frame_strobe, advance exactly once and return to PAUSE.
    - Further step_req pulses are ignored; there is no queueing.
    - run_toggle goes to RUN and discards the pending step.
- Simultaneous events:
  - run_toggle with frame_strobe in RUN: the strobe is processed with RUN semantics (an advance may occur), and the next state is PAUSE.
  - run_toggle with frame_strobe in STEP: the step advance occurs, and the next state is RUN with frame_cnt = 0.
  - step_req with run_toggle in PAUSE: run_toggle wins; next state is RUN and the step is dropped.
- Reset mid-operation: any state, mid-frame, returns to the reset values on the next edge. No strobe is generated by reset itself.
- frame_cnt width is 4 bits. It never exceeds 14, because the compare is >= against spd <= 15.
- Inputs are assumed to be synchronous pulses from the existing debounce logic. No internal edge detection.

Test Plan:
1. Reset, speed = 1, dir = 0, run 45 frames → offset 0,1,…,40,0,1,2,3,4. wrap pulses once, at the 41st strobe. Each change occurs exactly 2 cycles after (sx, sy) = (0, 480).
2. speed = 3, dir = 0 → offset increments every 3rd strobe. Then change speed to 1 with frame_cnt = 2 → advance on the next strobe. speed = 0 behaves identically to speed = 1.
3. dir = 1 from reset, speed = 1 → offset 0→40 with wrap, then 39, 38. Flip dir to 0 at offset 38 → next value is 39.
4. Pause at offset 10, let 5 frames pass → offset stays 10. Pulse step_req 3 times before the next strobe → exactly one advance, to 11, and state returns to PAUSE (running = 0).
5. In RUN with speed = 1, assert run_toggle in the frame_strobe cycle → offset advances once, running = 0, no further advances. In STEP, run_toggle coincident with the strobe → one advance, running = 1.
6. Assert rst for 1 cycle mid-frame at offset 25 in PAUSE → shift_offset = 0, running = 1, wrap = 0. Scrolling resumes at the following frame strobe.
